uart_rx: RTL and testbench

//  UART receive engine, counterpart of the codebase's UART transmitter. Recovers 8N1/8E1/8O1/8M1

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 42 ++++
 rtl/uart_rx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-type codes, receiver/transmitter state
// encoding and the parity helper used to build or check the parity bit.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_MARK = 2'b10;
    localparam logic [1:0] PAR_ODD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity bit that accompanies a byte for the given parity type.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] ptype);
        logic p;
        case (ptype)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Reset-to-1 synchronizer for the asynchronous rx line plus a falling-edge
// detector on the synchronized value. The line idles high, so presetting the
// chain to 1 keeps reset release from looking like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rxs,
    output logic rx_fall
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("uart_rx_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Shift the raw line through the metastability chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= rxs;
        end
    end

    assign rxs     = sync_r[SYNC_STAGES-1];
    assign rx_fall = prev_r & ~rxs;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine (8N1/8E1/8O1/8M1). Bit timing comes from baud_divisor,
// samples are taken mid-bit, good bytes are written to the RX FIFO and
// parity/framing/overrun errors are flagged as one-cycle pulses.
// Optional build macro UART_RX_MAJORITY_EN: each sample becomes a 2-of-3
// majority around the sample point, decided one clock later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [15:0] baud_divisor,
    input  logic [1:0]  i_parity_type,
    input  logic        i_fifo_full,
    output logic        o_fifo_wr_en,
    output logic [7:0]  rx_data,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_overrun_err,
    output logic        o_busy
);

    if (CLK_FREQ < 1) begin : g_bad_clk
        $error("uart_rx: CLK_FREQ must be positive");
    end

    logic        rxs_s;
    logic        rx_fall_s;
    logic [15:0] mid_s;
    logic [15:0] last_s;
    logic        cnt_wrap_s;
    logic [15:0] cnt_next_s;
    logic        bit_s;
    logic        start_hit_s;
    logic        bit_hit_s;
    logic [15:0] cnt_reload_s;

    uart_state_e state_r;
    logic [15:0] bit_cnt_r;
    logic [2:0]  data_idx_r;
    logic [7:0]  shift_r;
    logic        par_err_r;
    logic        wr_en_r;
    logic [7:0]  rx_data_r;
    logic        parity_err_r;
    logic        frame_err_r;
    logic        overrun_err_r;
    logic        busy_r;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rxs     (rxs_s),
        .rx_fall (rx_fall_s)
    );

    assign mid_s      = baud_divisor >> 1;
    assign last_s     = baud_divisor - 16'd1;
    assign cnt_wrap_s = (bit_cnt_r == last_s);
    assign cnt_next_s = cnt_wrap_s ? 16'd0 : (bit_cnt_r + 16'd1);

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d1_r;
    logic rxs_d2_r;

    // Two-deep history of rxs so the majority sees point-1, point and point+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_d1_r <= 1'b1;
            rxs_d2_r <= 1'b1;
        end else begin
            rxs_d1_r <= rxs_s;
            rxs_d2_r <= rxs_d1_r;
        end
    end

    // Decisions land one clock after the nominal point; entering DATA with
    // the counter at 1 keeps every later sample point centred in its bit.
    assign bit_s        = (rxs_d2_r & rxs_d1_r) | (rxs_d2_r & rxs_s) | (rxs_d1_r & rxs_s);
    assign start_hit_s  = (bit_cnt_r == (mid_s + 16'd1));
    assign bit_hit_s    = (bit_cnt_r == 16'd0);
    assign cnt_reload_s = 16'd1;
`else
    assign bit_s        = rxs_s;
    assign start_hit_s  = (bit_cnt_r == mid_s);
    assign bit_hit_s    = cnt_wrap_s;
    assign cnt_reload_s = 16'd0;
`endif

    // Frame FSM: bit timing, shifting, error evaluation and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 16'd0;
            data_idx_r    <= 3'd0;
            shift_r       <= 8'd0;
            par_err_r     <= 1'b0;
            wr_en_r       <= 1'b0;
            rx_data_r     <= 8'd0;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            wr_en_r       <= 1'b0;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 16'd0;
                    if (rx_fall_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (start_hit_s) begin
                        if (!bit_s) begin
                            state_r    <= DATA;
                            bit_cnt_r  <= cnt_reload_s;
                            data_idx_r <= 3'd0;
                            par_err_r  <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r   <= IDLE;
                            bit_cnt_r <= 16'd0;
                            busy_r    <= 1'b0;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    bit_cnt_r <= cnt_next_s;
                    if (bit_hit_s) begin
                        shift_r    <= {bit_s, shift_r[7:1]};
                        data_idx_r <= data_idx_r + 3'd1;
                        if (data_idx_r == 3'd7) begin
                            state_r <= (i_parity_type != PAR_NONE) ? PARITY : STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                PARITY: begin
                    bit_cnt_r <= cnt_next_s;
                    if (bit_hit_s) begin
                        par_err_r <= (bit_s != parity_bit(shift_r, i_parity_type));
                        state_r   <= STOP;
                    end else begin
                        state_r <= PARITY;
                    end
                end
                STOP: begin
                    if (bit_hit_s) begin
                        state_r      <= IDLE;
                        bit_cnt_r    <= 16'd0;
                        busy_r       <= 1'b0;
                        parity_err_r <= par_err_r;
                        if (bit_s) begin
                            rx_data_r <= shift_r;
                            if (i_fifo_full) begin
                                overrun_err_r <= 1'b1;
                            end else begin
                                wr_en_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= cnt_next_s;
                        state_r   <= STOP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= 16'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_wr_en  = wr_en_r;
    assign rx_data       = rx_data_r;
    assign o_parity_err  = parity_err_r;
    assign o_frame_err   = frame_err_r;
    assign o_overrun_err = overrun_err_r;
    assign o_busy        = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are bit-banged onto rx, the
// expected outcome of each frame is queued when it is sent and compared
// when the receiver raises a strobe or error pulse.
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_divisor = 16'd16;
    logic [1:0]  i_parity_type = PAR_NONE;
    logic        i_fifo_full = 1'b0;
    logic        o_fifo_wr_en;
    logic [7:0]  rx_data;
    logic        o_parity_err;
    logic        o_frame_err;
    logic        o_overrun_err;
    logic        o_busy;

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       oerr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .baud_divisor  (baud_divisor),
        .i_parity_type (i_parity_type),
        .i_fifo_full   (i_fifo_full),
        .o_fifo_wr_en  (o_fifo_wr_en),
        .rx_data       (rx_data),
        .o_parity_err  (o_parity_err),
        .o_frame_err   (o_frame_err),
        .o_overrun_err (o_overrun_err),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic ref_par(input logic [7:0] d, input logic [1:0] t);
        case (t)
            2'b01:   return ^d;
            2'b11:   return ~^d;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: every strobe/error pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && (o_fifo_wr_en || o_parity_err || o_frame_err || o_overrun_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_en", {31'd0, o_fifo_wr_en}, {31'd0, e.wr});
                check("parity_err", {31'd0, o_parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, o_frame_err}, {31'd0, e.ferr});
                check("overrun_err", {31'd0, o_overrun_err}, {31'd0, e.oerr});
                if (e.wr || e.oerr) begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (int'(baud_divisor)) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic has_par, input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk);
        check({tag, "_drain"}, sb.size(), 32'd0);
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic force_p,
                         input logic pval, input logic stop);
        exp_t e;
        logic good_p;
        logic sent_p;
        good_p = ref_par(d, i_parity_type);
        sent_p = force_p ? pval : good_p;
        e.data = d;
        e.perr = (i_parity_type != PAR_NONE) && (sent_p != good_p);
        e.ferr = !stop;
        e.wr   = stop && !i_fifo_full;
        e.oerr = stop && i_fifo_full;
        sb.push_back(e);
        send(d, i_parity_type != PAR_NONE, sent_p, stop);
        finish_frame(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic       saw_busy;
        logic [7:0] d;
        logic [7:0] brk;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {19'd0, o_fifo_wr_en, o_parity_err, o_frame_err, o_overrun_err, o_busy, rx_data},
              32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 basic byte
        frame("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1_rx_data_held", {24'd0, rx_data}, 32'h0000_00A5);

        // even parity, wrong parity bit: byte written together with parity error
        i_parity_type = PAR_EVEN;
        frame("t2_par_err", 8'h03, 1'b1, 1'b1, 1'b1);
        frame("t2_even_ok", 8'h07, 1'b0, 1'b0, 1'b1);

        // odd and mark parity, good and bad
        i_parity_type = PAR_ODD;
        frame("odd_ok", 8'h81, 1'b0, 1'b0, 1'b1);
        frame("odd_bad", 8'h81, 1'b1, 1'b0, 1'b1);
        i_parity_type = PAR_MARK;
        frame("mark_ok", 8'h00, 1'b0, 1'b0, 1'b1);
        frame("mark_bad", 8'hFF, 1'b1, 1'b0, 1'b1);
        frame("mark_bad_frame", 8'h3C, 1'b1, 1'b0, 1'b0);

        // framing error then a clean frame
        i_parity_type = PAR_NONE;
        frame("t3_frame_err", 8'h5A, 1'b0, 1'b0, 1'b0);
        frame("t3_recover", 8'h11, 1'b0, 1'b0, 1'b1);

        // overrun while FIFO full, then normal write
        i_fifo_full = 1'b1;
        frame("t4_overrun", 8'h7E, 1'b0, 1'b0, 1'b1);
        check("t4_rx_data_kept", {24'd0, rx_data}, 32'h0000_007E);
        i_fifo_full = 1'b0;
        frame("t4_after_full", 8'h7F, 1'b0, 1'b0, 1'b1);

        // short glitch: receiver goes busy, rejects it, no strobes
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_busy) saw_busy = 1'b1;
        end
        check("t5_glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
        check("t5_glitch_busy_end", {31'd0, o_busy}, 32'd0);
        check("t5_glitch_no_event", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // reset in the middle of data bit 4
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_reset_outputs",
              {19'd0, o_fifo_wr_en, o_parity_err, o_frame_err, o_overrun_err, o_busy, rx_data},
              32'd0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        frame("t6_after_reset", 8'hC3, 1'b0, 1'b0, 1'b1);

        // break: exactly one framing error, then a clean frame
        begin
            exp_t e;
            e = '0;
            e.ferr = 1'b1;
            sb.push_back(e);
        end
        rx = 1'b0;
        repeat (25 * 16) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * 16) @(posedge clk);
        #1;
        finish_frame("break");
        brk = 8'h96;
        frame("break_recover", brk, 1'b0, 1'b0, 1'b1);

        // minimum divisor with random bytes, parity types and parity faults
        baud_divisor = 16'd4;
        repeat (10) @(posedge clk);
        #1;
        frame("div4_00", 8'h00, 1'b0, 1'b0, 1'b1);
        frame("div4_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic bad;
            d = 8'($urandom_range(0, 255));
            i_parity_type = 2'($urandom_range(0, 3));
            bad = 1'($urandom_range(0, 1));
            frame("div4_rand", d, bad, ~ref_par(d, i_parity_type), 1'b1);
        end

        check("final_queue_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
